if_stage: RTL and testbench

Instruction fetch stage of the RV64 core. Owns the program counter and issues one 32-bit fetch at a time to instruction memory over a valid/ready request channel with a fixed-order response. Holds each fetched instruction and its address in an output register for the decode stage. Decode or execute can redirect the PC, and any fetch that is in flight at that moment is discarded.

---
 rtl/if_stage_pkg.sv | 23 ++
 rtl/pc_reg.sv | 30 +++
 rtl/if_stage.sv | 114 +++++++++++
 tb/tb_if_stage.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared widths, reset PC and FSM encodings for the RV64 instruction fetch stage.
package if_stage_pkg;

    localparam int unsigned REG_W  = 64;
    localparam int unsigned INST_W = 32;

    typedef logic [REG_W-1:0]  reg_bus_t;
    typedef logic [INST_W-1:0] inst_bus_t;

    localparam reg_bus_t PC_START = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_REQ  = 2'd1,
        IF_WAIT = 2'd2
    } if_state_e;

    // Instruction addresses are always word aligned.
    function automatic reg_bus_t align_pc(input reg_bus_t addr);
        return {addr[REG_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter: holds the fetch PC, steps it by 4 and takes redirects.
module pc_reg
    import if_stage_pkg::*;
#(
    parameter reg_bus_t RESET_PC = PC_START
)(
    input  logic     clk,
    input  logic     rst,
    input  logic     inc,
    input  logic     redirect_valid,
    input  reg_bus_t redirect_target,
    output reg_bus_t pc
);

    reg_bus_t r_pc;

    // Redirect wins over the increment; the add wraps modulo 2^64.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= align_pc(redirect_target);
        end else if (inc) begin
            r_pc <= r_pc + REG_W'(4);
        end
    end

    assign pc = r_pc;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding fetch, output register for decode,
// redirect with discard of any fetch still in flight.
module if_stage
    import if_stage_pkg::*;
#(
    parameter reg_bus_t RESET_PC = PC_START
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [REG_W-1:0]  redirect_target,
    output logic              inst_req_valid,
    input  logic              inst_req_ready,
    output logic [REG_W-1:0]  inst_req_addr,
    input  logic              inst_rsp_valid,
    input  logic [INST_W-1:0] inst_rsp_data,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [REG_W-1:0]  inst_addr
);

    if_state_e r_state;
    if_state_e w_state_nxt;
    logic      r_drop;
    logic      r_inst_valid;
    inst_bus_t r_inst;
    reg_bus_t  r_inst_addr;
    reg_bus_t  w_pc;

    logic w_redirect;
    logic w_free;
    logic w_req_valid;
    logic w_req_fire;
    logic w_rsp;
    logic w_load;

    pc_reg #(
        .RESET_PC        (RESET_PC)
    ) u_pc_reg (
        .clk             (clk),
        .rst             (rst),
        .inc             (w_load),
        .redirect_valid  (w_redirect),
        .redirect_target (redirect_target),
        .pc              (w_pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IF_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A response always closes the outstanding fetch, kept or dropped.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IF_IDLE: w_state_nxt = IF_REQ;
            IF_REQ:  if (w_req_fire) w_state_nxt = IF_WAIT;
            IF_WAIT: if (inst_rsp_valid) w_state_nxt = IF_REQ;
            default: w_state_nxt = IF_IDLE;
        endcase
    end

    // Request only when the output register will be free next cycle;
    // a redirect suppresses the request so the stale PC is never accepted.
    always_comb begin
        w_redirect  = redirect_valid && (r_state != IF_IDLE);
        w_free      = !r_inst_valid || !stall;
        w_req_valid = (r_state == IF_REQ) && w_free && !w_redirect;
        w_req_fire  = w_req_valid && inst_req_ready;
        w_rsp       = (r_state == IF_WAIT) && inst_rsp_valid;
        w_load      = w_rsp && !r_drop && !w_redirect;
    end

    // drop marks a response still owed for a fetch killed by redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop <= 1'b0;
        end else if (r_state == IF_WAIT) begin
            if (inst_rsp_valid) begin
                r_drop <= 1'b0;
            end else if (w_redirect) begin
                r_drop <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inst_valid <= 1'b0;
            r_inst       <= '0;
            r_inst_addr  <= '0;
        end else if (w_redirect) begin
            r_inst_valid <= 1'b0;
        end else if (w_load) begin
            r_inst_valid <= 1'b1;
            r_inst       <= inst_rsp_data;
            r_inst_addr  <= w_pc;
        end else if (r_inst_valid && !stall) begin
            r_inst_valid <= 1'b0;
        end
    end

    assign inst_req_valid = w_req_valid;
    assign inst_req_addr  = w_pc;
    assign inst_valid     = r_inst_valid;
    assign inst           = r_inst;
    assign inst_addr      = r_inst_addr;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus a randomized run against a
// queue-based fetch model with a memory that answers with random latency.
module tb_if_stage;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [63:0] redirect_target;
    logic        inst_req_valid;
    logic        inst_req_ready;
    logic [63:0] inst_req_addr;
    logic        inst_rsp_valid;
    logic [31:0] inst_rsp_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [63:0] inst_addr;

    int n_tests = 0;
    int n_fail  = 0;

    // memory-side state
    bit          pend;
    int          pend_cnt;
    logic [63:0] pend_addr;
    bit          pend_at_start;
    bit          rsp_now;
    logic [63:0] rsp_addr;
    bit          hs_now;

    if_stage #(.RESET_PC(RST_PC)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .inst_req_valid  (inst_req_valid),
        .inst_req_ready  (inst_req_ready),
        .inst_req_addr   (inst_req_addr),
        .inst_rsp_valid  (inst_rsp_valid),
        .inst_rsp_data   (inst_rsp_data),
        .inst_valid      (inst_valid),
        .inst            (inst),
        .inst_addr       (inst_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_data(input logic [63:0] a);
        return 32'(a << 7) | 32'h13;
    endfunction

    // One clock cycle: drive inputs after negedge, memory answers, sample comb outputs.
    task automatic cycle(input bit r, input bit st, input bit rv, input logic [63:0] rt,
                         input bit rdy, input int dly);
        @(negedge clk);
        rst = r; stall = st; redirect_valid = rv; redirect_target = rt; inst_req_ready = rdy;
        pend_at_start = pend;
        rsp_now = 1'b0;
        hs_now  = 1'b0;
        if (pend && pend_cnt == 0) begin
            inst_rsp_valid = 1'b1;
            inst_rsp_data  = mem_data(pend_addr);
            rsp_now  = 1'b1;
            rsp_addr = pend_addr;
            pend     = 1'b0;
        end else begin
            inst_rsp_valid = 1'b0;
            inst_rsp_data  = $urandom;
            if (pend) pend_cnt--;
        end
        #1;
        if (inst_req_valid === 1'b1 && inst_req_ready) begin
            hs_now    = 1'b1;
            pend      = 1'b1;
            pend_addr = inst_req_addr;
            pend_cnt  = dly - 1;
        end
    endtask

    task automatic apply_reset();
        pend = 1'b0;
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1);
        cycle(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1);
    endtask

    task automatic test_reset();
        pend = 1'b0;
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 64'h0, 1'b1, 1);
        n_tests++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_inst_valid got=%b exp=0", inst_valid); end
        n_tests++; if (inst !== 32'h0) begin n_fail++; $display("FAIL reset_inst got=%h exp=0", inst); end
        n_tests++; if (inst_addr !== 64'h0) begin n_fail++; $display("FAIL reset_inst_addr got=%h exp=0", inst_addr); end
        n_tests++; if (inst_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid got=%b exp=0", inst_req_valid); end
        cycle(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1);
        n_tests++; if (inst_req_valid !== 1'b0) begin n_fail++; $display("FAIL idle_req_valid got=%b exp=0", inst_req_valid); end
        cycle(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1);
        n_tests++; if (inst_req_valid !== 1'b1 || inst_req_addr !== RST_PC) begin
            n_fail++; $display("FAIL first_req got v=%b a=%h exp v=1 a=%h", inst_req_valid, inst_req_addr, RST_PC); end
        cycle(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1);
        n_tests++; if (inst_rsp_data !== 32'h0000_0013 || inst_valid !== 1'b0) begin
            n_fail++; $display("FAIL first_rsp got data=%h v=%b exp data=00000013 v=0", inst_rsp_data, inst_valid); end
        cycle(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1);
        n_tests++; if (inst_valid !== 1'b1 || inst_addr !== RST_PC || inst !== 32'h0000_0013) begin
            n_fail++; $display("FAIL first_inst got v=%b a=%h i=%h exp v=1 a=%h i=00000013", inst_valid, inst_addr, inst, RST_PC); end
    endtask

    task automatic test_streaming();
        logic        exp_v;
        logic [63:0] ea;
        apply_reset();
        for (int c = 0; c < 8; c++) begin
            cycle(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1);
            exp_v = (c >= 2) && (c % 2 == 0);
            n_tests++; if (inst_valid !== exp_v) begin n_fail++; $display("FAIL stream_valid c=%0d got=%b exp=%b", c, inst_valid, exp_v); end
            if (exp_v) begin
                ea = RST_PC + 64'(4 * ((c - 2) / 2));
                n_tests++; if (inst_addr !== ea || inst !== mem_data(ea)) begin
                    n_fail++; $display("FAIL stream_inst c=%0d got a=%h i=%h exp a=%h i=%h", c, inst_addr, inst, ea, mem_data(ea)); end
            end
            if (c % 2 == 0) begin
                ea = RST_PC + 64'(4 * (c / 2));
                n_tests++; if (inst_req_valid !== 1'b1 || inst_req_addr !== ea) begin
                    n_fail++; $display("FAIL stream_req c=%0d got v=%b a=%h exp v=1 a=%h", c, inst_req_valid, inst_req_addr, ea); end
            end
        end
    endtask

    task automatic test_stall();
        apply_reset();
        cycle(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1);
        cycle(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1);
        for (int c = 0; c < 5; c++) begin
            cycle(1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 1);
            n_tests++; if (inst_valid !== 1'b1 || inst_addr !== RST_PC || inst !== mem_data(RST_PC)) begin
                n_fail++; $display("FAIL stall_hold c=%0d got v=%b a=%h i=%h exp v=1 a=%h", c, inst_valid, inst_addr, inst, RST_PC); end
            n_tests++; if (inst_req_valid !== 1'b0) begin n_fail++; $display("FAIL stall_noreq c=%0d got=%b exp=0", c, inst_req_valid); end
        end
        cycle(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1);
        n_tests++; if (inst_req_valid !== 1'b1 || inst_req_addr !== RST_PC + 64'd4) begin
            n_fail++; $display("FAIL stall_release_req got v=%b a=%h exp v=1 a=%h", inst_req_valid, inst_req_addr, RST_PC + 64'd4); end
        cycle(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1);
        n_tests++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL stall_consumed got=%b exp=0", inst_valid); end
        cycle(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1);
        n_tests++; if (inst_valid !== 1'b1 || inst_addr !== RST_PC + 64'd4) begin
            n_fail++; $display("FAIL stall_next got v=%b a=%h exp v=1 a=%h", inst_valid, inst_addr, RST_PC + 64'd4); end
    endtask

    task automatic test_redirect_wait();
        apply_reset();
        cycle(1'b0, 1'b0, 1'b1, 64'h0000_0000_8000_0010, 1'b1, 1);
        n_tests++; if (inst_req_valid !== 1'b0) begin n_fail++; $display("FAIL rdw_req_on_redirect got=%b exp=0", inst_req_valid); end
        cycle(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 3);
        n_tests++; if (inst_req_valid !== 1'b1 || inst_req_addr !== 64'h0000_0000_8000_0010) begin
            n_fail++; $display("FAIL rdw_req10 got v=%b a=%h exp v=1 a=0000000080000010", inst_req_valid, inst_req_addr); end
        cycle(1'b0, 1'b0, 1'b1, 64'h0000_0000_8000_0103, 1'b1, 1);
        cycle(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1);
        n_tests++; if (inst_req_valid !== 1'b0) begin n_fail++; $display("FAIL rdw_owed_noreq got=%b exp=0", inst_req_valid); end
        cycle(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1);
        n_tests++; if (inst_valid !== 1'b0 || inst_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL rdw_stale_rsp got v=%b rv=%b exp v=0 rv=0", inst_valid, inst_req_valid); end
        cycle(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1);
        n_tests++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rdw_dropped got=%b exp=0", inst_valid); end
        n_tests++; if (inst_req_valid !== 1'b1 || inst_req_addr !== 64'h0000_0000_8000_0100) begin
            n_fail++; $display("FAIL rdw_target_req got v=%b a=%h exp v=1 a=0000000080000100", inst_req_valid, inst_req_addr); end
        cycle(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1);
        cycle(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1);
        n_tests++; if (inst_valid !== 1'b1 || inst_addr !== 64'h0000_0000_8000_0100 || inst !== mem_data(64'h8000_0100)) begin
            n_fail++; $display("FAIL rdw_target_inst got v=%b a=%h i=%h exp v=1 a=0000000080000100", inst_valid, inst_addr, inst); end
    endtask

    task automatic test_redirect_simul();
        apply_reset();
        cycle(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1);
        cycle(1'b0, 1'b0, 1'b1, 64'h0000_0000_8000_0200, 1'b1, 1);
        cycle(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1);
        n_tests++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL simul_discard got=%b exp=0", inst_valid); end
        n_tests++; if (inst_req_valid !== 1'b1 || inst_req_addr !== 64'h0000_0000_8000_0200) begin
            n_fail++; $display("FAIL simul_req got v=%b a=%h exp v=1 a=0000000080000200", inst_req_valid, inst_req_addr); end
        cycle(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1);
        cycle(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1);
        n_tests++; if (inst_valid !== 1'b1 || inst_addr !== 64'h0000_0000_8000_0200) begin
            n_fail++; $display("FAIL simul_inst got v=%b a=%h exp v=1 a=0000000080000200", inst_valid, inst_addr); end
    endtask

    task automatic test_wrap();
        apply_reset();
        cycle(1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1);
        cycle(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1);
        n_tests++; if (inst_req_valid !== 1'b1 || inst_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            n_fail++; $display("FAIL wrap_req_top got v=%b a=%h exp v=1 a=fffffffffffffffc", inst_req_valid, inst_req_addr); end
        cycle(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1);
        cycle(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1);
        n_tests++; if (inst_valid !== 1'b1 || inst_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            n_fail++; $display("FAIL wrap_inst got v=%b a=%h exp v=1 a=fffffffffffffffc", inst_valid, inst_addr); end
        n_tests++; if (inst_req_valid !== 1'b1 || inst_req_addr !== 64'h0) begin
            n_fail++; $display("FAIL wrap_req_zero got v=%b a=%h exp v=1 a=0", inst_req_valid, inst_req_addr); end
    endtask

    task automatic test_midfetch_reset();
        apply_reset();
        cycle(1'b0, 1'b0, 1'b1, 64'h0000_0000_8000_0040, 1'b1, 1);
        cycle(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 3);
        cycle(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1);
        cycle(1'b1, 1'b0, 1'b0, 64'h0, 1'b1, 1);
        cycle(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1);
        n_tests++; if (rsp_now !== 1'b1 || inst_valid !== 1'b0 || inst_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_rst_late_rsp got rsp=%b v=%b rv=%b exp rsp=1 v=0 rv=0", rsp_now, inst_valid, inst_req_valid); end
        cycle(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1);
        n_tests++; if (inst_valid !== 1'b0 || inst_req_valid !== 1'b1 || inst_req_addr !== RST_PC) begin
            n_fail++; $display("FAIL mid_rst_req got v=%b rv=%b a=%h exp v=0 rv=1 a=%h", inst_valid, inst_req_valid, inst_req_addr, RST_PC); end
        cycle(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1);
        cycle(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1);
        n_tests++; if (inst_valid !== 1'b1 || inst_addr !== RST_PC || inst !== mem_data(RST_PC)) begin
            n_fail++; $display("FAIL mid_rst_inst got v=%b a=%h i=%h exp v=1 a=%h", inst_valid, inst_addr, inst, RST_PC); end
    endtask

    // Model: next fetch address, plus a queue of instructions owed to decode.
    task automatic test_random();
        logic [63:0] exp_pc;
        logic [63:0] qa[$];
        logic [31:0] qd[$];
        bit          stale;
        bit          st, rv, rdy;
        int          dly;
        logic [63:0] rt;
        apply_reset();
        exp_pc = RST_PC;
        stale  = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rv  = ($urandom_range(0, 19) == 0);
            st  = ($urandom_range(0, 9) < 3);
            rdy = ($urandom_range(0, 9) < 6);
            dly = $urandom_range(1, 3);
            rt  = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) rt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            cycle(1'b0, st, rv, rt, rdy, dly);
            n_tests++; if (inst_valid !== (qa.size() != 0)) begin
                n_fail++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, inst_valid, qa.size() != 0); end
            if (qa.size() != 0 && inst_valid === 1'b1) begin
                n_tests++; if (inst_addr !== qa[0] || inst !== qd[0]) begin
                    n_fail++; $display("FAIL rnd_inst c=%0d got a=%h i=%h exp a=%h i=%h", c, inst_addr, inst, qa[0], qd[0]); end
            end
            if (inst_req_valid === 1'b1) begin
                n_tests++; if (inst_req_addr !== exp_pc) begin
                    n_fail++; $display("FAIL rnd_req_addr c=%0d got=%h exp=%h", c, inst_req_addr, exp_pc); end
                n_tests++; if (pend_at_start || (qa.size() != 0 && st) || rv) begin
                    n_fail++; $display("FAIL rnd_req_busy c=%0d got req=1 exp req=0 (owed=%b full=%b redir=%b)", c, pend_at_start, qa.size() != 0 && st, rv); end
            end
            if (rv) begin
                qa.delete();
                qd.delete();
                exp_pc = {rt[63:2], 2'b00};
                if (pend) stale = 1'b1;
            end else begin
                if (qa.size() != 0 && !st) begin
                    void'(qa.pop_front());
                    void'(qd.pop_front());
                end
                if (rsp_now && !stale) begin
                    qa.push_back(rsp_addr);
                    qd.push_back(mem_data(rsp_addr));
                    exp_pc = rsp_addr + 64'd4;
                end
            end
            if (rsp_now && !(rv && pend)) stale = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 64'h0;
        inst_req_ready = 1'b0; inst_rsp_valid = 1'b0; inst_rsp_data = 32'h0;
        pend = 1'b0; pend_cnt = 0; pend_addr = 64'h0; rsp_addr = 64'h0;
        test_reset();
        test_streaming();
        test_stall();
        test_redirect_wait();
        test_redirect_simul();
        test_wrap();
        test_midfetch_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
